riscv_test_monitor: RTL
=======================

// Module: riscv_test_monitor
// PURPOSE
//  Synthesizable pass/fail monitor for riscv-tests (rv32ui/um-p-*). It sits beside top and snoops the
//  register-file write port, so simulation and FPGA runs share one check. It detects the test-done
//  write, waits a settle window, then reports pass/fail, failing test number, timeout and cycle count.
//  Console byte writes to a chosen register are forwarded as a valid/data stream.
// PARAMETERS
//  XLEN          32      register data width
//  DONE_REG      26      reg index whose write of 1 marks end of test
//  PASS_REG      27      reg index holding 1 on pass
//  TNUM_REG      3       reg index holding current test number
//  CON_REG       15      reg index used as console byte output; 0 disables console
//  SETTLE_CYC    20      cycles waited after done before verdict (>=1)
//  TIMEOUT_CYC   200000  run cycles before TIMEOUT verdict; 0 disables watchdog
//  CNT_W         32      cycle counter width
// PORTS
//  clk           in   1      core clock
//  rst           in   1      asynchronous, active-high reset
//  arm_i         in   1      1-cycle pulse: clear shadows/counter, enter RUN
//  we_i          in   1      regfile write enable (snooped)
//  waddr_i       in   5      regfile write address
//  wdata_i       in   XLEN   regfile write data
//  done_o        out  1      verdict valid (sticky until arm_i/rst)
//  pass_o        out  1      verdict = pass
//  fail_o        out  1      verdict = fail
//  timeout_o     out  1      verdict = watchdog expiry
//  testnum_o     out  XLEN   last TNUM_REG value seen
//  cycles_o      out  CNT_W  cycles spent in RUN+SETTLE
//  con_valid_o   out  1      1-cycle pulse per CON_REG write
//  con_data_o    out  8      wdata_i[7:0] of that write
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, shadows (pass_sh, tnum_sh), cycles, settle count = 0.
//  Snoop: a write counts only when we_i=1 and waddr_i!=0; waddr_i=0 writes are ignored everywhere.
//  Shadows: PASS_REG/TNUM_REG writes update pass_sh/tnum_sh in every state except IDLE and a
//   verdict state; testnum_o = tnum_sh.
//  FSM:
//   IDLE    -> RUN on arm_i.
//   RUN     cycles++ every cycle (saturates at all-ones, no wrap). DONE_REG write with wdata_i==1
//           -> SETTLE, settle count=0. Writes of other values to DONE_REG are ignored. If
//           TIMEOUT_CYC!=0 and cycles==TIMEOUT_CYC-1 with no done write -> TIMEOUT. If both occur
//           the same cycle, done wins.
//   SETTLE  cycles++; shadows keep updating; after SETTLE_CYC cycles -> PASS if pass_sh==1, else FAIL.
//           Watchdog inactive. A pass_sh write on the last settle cycle is included in the verdict.
//   PASS/FAIL/TIMEOUT: terminal. done_o=1, exactly one of pass_o/fail_o/timeout_o=1. Registered
//           outputs; asserted in the cycle after the transition. Counter frozen.
//  arm_i in any state: same-cycle priority over all other events. Clears shadows, cycles,
//   verdict outputs -> RUN (re-arm mid-run restarts the test).
//  Console: when CON_REG!=0 and a CON_REG write occurs, con_valid_o=1 and con_data_o=wdata_i[7:0]
//   next cycle, in any state incl. IDLE. Back-to-back writes give back-to-back pulses; no buffering.
//  Latency: snoop -> shadow/console output is 1 cycle.
//  rst asserted mid-operation: immediate return to reset values; no verdict is emitted.
// STRUCTURE
//  Shared package/include (alongside ins_defines.v): monitor state encodings MON_IDLE, MON_RUN,
//   MON_SETTLE, MON_PASS, MON_FAIL, MON_TIMEOUT; default reg indices for DONE/PASS/TNUM/CON.
//  One sub-module: mon_sat_counter (CNT_W, clear, enable, saturate), used for cycles and settle.
//  tb instantiates the monitor on u_top.u_regs write port; tb prints verdict from done_o.
// TESTING
//  1 arm; write x3=5, x27=1, x26=1 -> 20 cycles later done=1, pass=1, testnum_o=5, fail=timeout=0.
//  2 arm; x3=7, x27=0, x26=1 -> fail=1, testnum_o=7. Repeat, but write x27=1 on last settle cycle
//    -> pass=1.
//  3 TIMEOUT_CYC=50; arm, no x26 write -> timeout=1 after 50 cycles, cycles_o=50. Done write on
//    cycle 49 -> SETTLE, no timeout.
//  4 x26=2 then x0 writes of 1 to "26" index 0 -> no done. Then x26=1 -> done.
//  5 x15 writes 'O','K' back-to-back -> two con_valid pulses, data 0x4F, 0x4B. CON_REG=0 -> none.
//  6 arm mid-SETTLE -> RUN, cycles 0, outputs clear. rst asserted mid-RUN -> all outputs 0, IDLE.

Source files
------------

// File: rtl/riscv_test_monitor_pkg.sv
// Purpose: shared monitor state encodings and default register indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_test_monitor_pkg;

  typedef enum logic [2:0] {
    MON_IDLE    = 3'd0,
    MON_RUN     = 3'd1,
    MON_SETTLE  = 3'd2,
    MON_PASS    = 3'd3,
    MON_FAIL    = 3'd4,
    MON_TIMEOUT = 3'd5
  } mon_state_e;

  // riscv-tests ABI: x26 = done flag, x27 = pass flag, x3 (gp) = test number,
  // x15 = console byte register.
  localparam logic [4:0] DEF_DONE_REG = 5'd26;
  localparam logic [4:0] DEF_PASS_REG = 5'd27;
  localparam logic [4:0] DEF_TNUM_REG = 5'd3;
  localparam logic [4:0] DEF_CON_REG  = 5'd15;

  // The cycle counter only advances while a test is in flight.
  function automatic logic is_counting(mon_state_e s);
    return (s == MON_RUN) || (s == MON_SETTLE);
  endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Purpose: bundles the snooped regfile write port, arm strobe and monitor results.
// Latency: n/a (wires only).
// Backpressure: none; the monitor is a passive observer and every output is a pulse or level.
// Ports: arm_i/we_i/waddr_i/wdata_i driven by master; verdict, testnum, cycles and console
//        stream driven by slave (the monitor).
interface riscv_test_monitor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             arm_i;
  logic             we_i;
  logic [4:0]       waddr_i;
  logic [XLEN-1:0]  wdata_i;
  logic             done_o;
  logic             pass_o;
  logic             fail_o;
  logic             timeout_o;
  logic [XLEN-1:0]  testnum_o;
  logic [CNT_W-1:0] cycles_o;
  logic             con_valid_o;
  logic [7:0]       con_data_o;

  modport master (
    output arm_i, we_i, waddr_i, wdata_i,
    input  done_o, pass_o, fail_o, timeout_o, testnum_o, cycles_o, con_valid_o, con_data_o
  );

  modport slave (
    input  arm_i, we_i, waddr_i, wdata_i,
    output done_o, pass_o, fail_o, timeout_o, testnum_o, cycles_o, con_valid_o, con_data_o
  );
endinterface

// File: rtl/riscv_test_monitor_mon_sat_counter.sv
// Purpose: up-counter with synchronous clear and enable that sticks at all-ones.
// Latency: count visible 1 cycle after enable.
// Backpressure: none.
// Ports: clk, rst (async, active-high), clr (priority over en), en, cnt.
module mon_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Purpose: riscv-tests pass/fail monitor snooping the regfile write port, plus console byte tap.
// Latency: snoop -> shadow/console 1 cycle; done write -> verdict SETTLE_CYC cycles.
// Backpressure: none; console pulses are unbuffered and track regfile writes one-for-one.
// Ports: clk, rst (async, active-high), mon (slave modport: arm/snoop in, verdict/counters/console out).
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [4:0]  DONE_REG    = DEF_DONE_REG,
  parameter logic [4:0]  PASS_REG    = DEF_PASS_REG,
  parameter logic [4:0]  TNUM_REG    = DEF_TNUM_REG,
  parameter logic [4:0]  CON_REG     = DEF_CON_REG,
  parameter int unsigned SETTLE_CYC  = 20,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int          CNT_W       = 32
) (
  input logic                 clk,
  input logic                 rst,
  riscv_test_monitor_if.slave mon
);

  localparam int               SET_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic             TO_EN       = (TIMEOUT_CYC != 0);
  localparam logic             CON_EN      = (CON_REG != 5'd0);
  localparam logic [XLEN-1:0]  ONE_X       = {{(XLEN-1){1'b0}}, 1'b1};

  mon_state_e       state_q, state_d;
  logic             pass_sh;
  logic [XLEN-1:0]  tnum_sh;
  logic [CNT_W-1:0] cycles;
  logic [SET_W-1:0] settle_cnt;
  logic             done_q, pass_q, fail_q, timeout_q;
  logic             con_vld_q;
  logic [7:0]       con_dat_q;

  // Writes to x0 are architecturally dropped, so they never count as a hit.
  logic wr_vld, done_hit, pass_hit, tnum_hit, con_hit, shadow_en, wdata_is_one, pass_eff;

  assign wr_vld       = mon.we_i && (mon.waddr_i != 5'd0);
  assign wdata_is_one = (mon.wdata_i == ONE_X);
  assign done_hit     = wr_vld && (mon.waddr_i == DONE_REG) && wdata_is_one;
  assign pass_hit     = wr_vld && (mon.waddr_i == PASS_REG);
  assign tnum_hit     = wr_vld && (mon.waddr_i == TNUM_REG);
  assign con_hit      = CON_EN && wr_vld && (mon.waddr_i == CON_REG);
  assign shadow_en    = is_counting(state_q);

  // A pass-flag write on the final settle cycle must still steer the verdict.
  assign pass_eff     = (shadow_en && pass_hit) ? wdata_is_one : pass_sh;

  // Shadows: arm wipes them even if a write lands in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_sh <= 1'b0;
      tnum_sh <= '0;
    end else if (mon.arm_i) begin
      pass_sh <= 1'b0;
      tnum_sh <= '0;
    end else if (shadow_en) begin
      if (pass_hit) pass_sh <= wdata_is_one;
      if (tnum_hit) tnum_sh <= mon.wdata_i;
    end
  end

  mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (mon.arm_i),
    .en  (shadow_en),
    .cnt (cycles)
  );

  // Held at zero outside SETTLE so entry always starts a fresh window.
  mon_sat_counter #(.W(SET_W)) u_settle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (mon.arm_i || (state_q != MON_SETTLE)),
    .en  (state_q == MON_SETTLE),
    .cnt (settle_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MON_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mon.arm_i) begin
      state_d = MON_RUN;
    end else begin
      case (state_q)
        MON_RUN: begin
          // Done takes precedence over a watchdog expiry in the same cycle.
          if (done_hit)                          state_d = MON_SETTLE;
          else if (TO_EN && (cycles == TO_LAST)) state_d = MON_TIMEOUT;
        end
        MON_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state_d = pass_eff ? MON_PASS : MON_FAIL;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Verdict flags are registered off the next state so they rise with the state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pass_q    <= (state_d == MON_PASS);
      fail_q    <= (state_d == MON_FAIL);
      timeout_q <= (state_d == MON_TIMEOUT);
      done_q    <= (state_d == MON_PASS) || (state_d == MON_FAIL) || (state_d == MON_TIMEOUT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      con_vld_q <= 1'b0;
      con_dat_q <= 8'h00;
    end else begin
      con_vld_q <= con_hit;
      if (con_hit) con_dat_q <= mon.wdata_i[7:0];
    end
  end

  assign mon.done_o      = done_q;
  assign mon.pass_o      = pass_q;
  assign mon.fail_o      = fail_q;
  assign mon.timeout_o   = timeout_q;
  assign mon.testnum_o   = tnum_sh;
  assign mon.cycles_o    = cycles;
  assign mon.con_valid_o = con_vld_q;
  assign mon.con_data_o  = con_dat_q;

endmodule
